// File: rtl/data_mem_responder_if.sv
// Request/response bus between the load/store path and the data-memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian byte-addressed RAM slave: one request at a time, fixed wait states,
// registered response with zero-extended read data and an error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus,
  output logic       busy
);

  localparam int unsigned AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [AW-1:0] IDX1 = AW'(1);
  localparam logic [AW-1:0] IDX2 = AW'(2);
  localparam logic [AW-1:0] IDX3 = AW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic        l_write, l_write_nx;
  logic [1:0]  l_size, l_size_nx;
  logic [31:0] l_addr, l_addr_nx;
  logic [31:0] l_wdata, l_wdata_nx;

  logic        resp_valid_q, resp_valid_nx;
  logic [31:0] resp_rdata_q, resp_rdata_nx;
  logic        resp_error_q, resp_error_nx;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [32:0]   nbytes;
  logic [32:0]   end_addr;
  logic          access_err;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   load_data;
  logic          mem_we;

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    nbytes = 33'd1;
    case (l_size)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      2'b10:   nbytes = 33'd4;
      default: nbytes = 33'd1;
    endcase
    end_addr   = {1'b0, l_addr} + nbytes;
    access_err = (l_size == 2'b11)
              || ((l_size == 2'b01) && l_addr[0])
              || ((l_size == 2'b10) && (l_addr[1:0] != 2'b00))
              || (end_addr > 33'(DEPTH_BYTES));
  end

  always_comb begin
    a0 = l_addr[AW-1:0];
    a1 = a0 + IDX1;
    a2 = a0 + IDX2;
    a3 = a0 + IDX3;
  end

  always_comb begin
    load_data = '0;
    case (l_size)
      2'b00:   load_data = {24'h0, mem[a0]};
      2'b01:   load_data = {16'h0, mem[a0], mem[a1]};
      2'b10:   load_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    l_write_nx    = l_write;
    l_size_nx     = l_size;
    l_addr_nx     = l_addr;
    l_wdata_nx    = l_wdata;
    resp_valid_nx = resp_valid_q;
    resp_rdata_nx = resp_rdata_q;
    resp_error_nx = resp_error_q;
    mem_we        = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          l_write_nx = bus.req_write;
          l_size_nx  = bus.req_size;
          l_addr_nx  = bus.req_addr;
          l_wdata_nx = bus.req_wdata;
          cnt_nx     = 4'(WAIT_CYCLES);
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          mem_we        = l_write && !access_err;
          resp_valid_nx = 1'b1;
          resp_error_nx = access_err;
          resp_rdata_nx = (access_err || l_write) ? '0 : load_data;
          state_nx      = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_nx = 1'b0;
          state_nx      = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      l_write      <= 1'b0;
      l_size       <= '0;
      l_addr       <= '0;
      l_wdata      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      l_write      <= l_write_nx;
      l_size       <= l_size_nx;
      l_addr       <= l_addr_nx;
      l_wdata      <= l_wdata_nx;
      resp_valid_q <= resp_valid_nx;
      resp_rdata_q <= resp_rdata_nx;
      resp_error_q <= resp_error_nx;
    end
  end

  // Array is deliberately outside the reset domain; an async reset in WAIT
  // leaves state IDLE before the commit edge, so mem_we never fires.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (l_size)
        2'b00: mem[a0] <= l_wdata[7:0];
        2'b01: begin
          mem[a0] <= l_wdata[15:8];
          mem[a1] <= l_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= l_wdata[31:24];
          mem[a1] <= l_wdata[23:16];
          mem[a2] <= l_wdata[15:8];
          mem[a3] <= l_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances (2, 4 and 0 wait states)
// with expected responses queued at issue and compared by a negedge monitor.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic busy0, busy1, busy2;

  data_mem_if b0();
  data_mem_if b1();
  data_mem_if b2();

  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst0), .bus(b0.slave), .busy(busy0));
  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(4)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave), .busy(busy1));
  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .reset(rst2), .bus(b2.slave), .busy(busy2));

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   acc_cyc[3] = '{0, 0, 0};
  logic prev_v[3]  = '{1'b0, 1'b0, 1'b0};
  int   lat[3]     = '{3, 5, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_tot++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic set_req(input int d, input logic v, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    case (d)
      0: begin b0.req_valid = v; b0.req_write = w; b0.req_size = sz; b0.req_addr = a; b0.req_wdata = wd; end
      1: begin b1.req_valid = v; b1.req_write = w; b1.req_size = sz; b1.req_addr = a; b1.req_wdata = wd; end
      default: begin b2.req_valid = v; b2.req_write = w; b2.req_size = sz; b2.req_addr = a; b2.req_wdata = wd; end
    endcase
  endtask

  function automatic logic get_ready(input int d);
    case (d)
      0:       return b0.req_ready;
      1:       return b1.req_ready;
      default: return b2.req_ready;
    endcase
  endfunction

  task automatic push(input int d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.rd  = rd;
    e.err = err;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Issue one request; fields are scrambled right after acceptance so any
  // sensitivity to request inputs while busy shows up as a data error.
  task automatic send(input int d, input logic exp_resp, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err);
    int n = 0;
    if (exp_resp) push(d, rd, err);
    @(negedge clk);
    set_req(d, 1'b1, w, sz, a, wd);
    while (!get_ready(d) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail($sformatf("accept_dut%0d", d));
    @(posedge clk);
    #1;
    acc_cyc[d] = cyc;
    set_req(d, 1'b0, ~w, ~sz, ~a, ~wd);
  endtask

  task automatic wait_idle(input int d, output int t);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!get_ready(d) && n < 100);
    if (n >= 100) timeout_fail($sformatf("idle_dut%0d", d));
    t = cyc;
  endtask

  task automatic mon(input int d, input logic v, input logic r,
                     input logic [31:0] rd, input logic err);
    exp_t e;
    int   qs;
    if (v && !prev_v[d]) chk($sformatf("latency_dut%0d", d), 32'(cyc - acc_cyc[d]), 32'(lat[d]));
    prev_v[d] = v;
    if (v && r) begin
      qs = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      if (qs == 0) begin
        n_tot++;
        $display("FAIL unexpected_resp_dut%0d: got rdata %h expected no response", d, rd);
      end else begin
        case (d)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("rdata_dut%0d", d), rd, e.rd);
        chk($sformatf("error_dut%0d", d), {31'h0, err}, {31'h0, e.err});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.resp_valid, b0.resp_ready, b0.resp_rdata, b0.resp_error);
    mon(1, b1.resp_valid, b1.resp_ready, b1.resp_rdata, b1.resp_error);
    mon(2, b2.resp_valid, b2.resp_ready, b2.resp_rdata, b2.resp_error);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, nv;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    b0.resp_ready = 1'b1; b1.resp_ready = 1'b1; b2.resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, b0.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, b0.resp_valid}, 32'h0);
    chk("rst_resp_rdata", b0.resp_rdata, 32'h0);
    chk("rst_resp_error", {31'h0, b0.resp_error}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Word store/load and sub-word loads
    send(0, 1, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    send(0, 1, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    send(0, 1, 0, 2'b00, 32'h10, 32'h0, 32'h000000DE, 0);
    send(0, 1, 0, 2'b00, 32'h13, 32'h0, 32'h000000EF, 0);
    send(0, 1, 0, 2'b01, 32'h12, 32'h0, 32'h0000BEEF, 0);
    send(0, 1, 1, 2'b00, 32'h11, 32'hAABBCC55, 32'h0, 0);
    send(0, 1, 0, 2'b10, 32'h10, 32'h0, 32'hDE55BEEF, 0);
    send(0, 1, 1, 2'b10, 32'h14, 32'h00000000, 32'h0, 0);
    send(0, 1, 1, 2'b01, 32'h14, 32'hFFFF1234, 32'h0, 0);
    send(0, 1, 0, 2'b10, 32'h14, 32'h0, 32'h12340000, 0);

    // Error cases
    send(0, 1, 0, 2'b10, 32'h12, 32'h0, 32'h0, 1);
    send(0, 1, 0, 2'b01, 32'h11, 32'h0, 32'h0, 1);
    send(0, 1, 0, 2'b11, 32'h10, 32'h0, 32'h0, 1);
    send(0, 1, 0, 2'b10, 32'h3FE, 32'h0, 32'h0, 1);
    send(0, 1, 0, 2'b10, 32'hFFFFFFFC, 32'h0, 32'h0, 1);
    send(0, 1, 0, 2'b00, 32'h400, 32'h0, 32'h0, 1);
    send(0, 1, 1, 2'b00, 32'h3FE, 32'h000000A5, 32'h0, 0);
    send(0, 1, 1, 2'b10, 32'h3FE, 32'h11223344, 32'h0, 1);
    send(0, 1, 0, 2'b00, 32'h3FE, 32'h0, 32'h000000A5, 0);
    send(0, 1, 1, 2'b00, 32'h3FF, 32'h0000005A, 32'h0, 0);
    send(0, 1, 0, 2'b01, 32'h3FE, 32'h0, 32'h0000A55A, 0);
    wait_idle(0, t0);

    // Backpressure
    b0.resp_ready = 1'b0;
    send(0, 1, 0, 2'b10, 32'h10, 32'h0, 32'hDE55BEEF, 0);
    nv = 0;
    while (!b0.resp_valid && nv < 50) begin
      @(posedge clk);
      #1;
      nv++;
    end
    if (nv >= 50) timeout_fail("bp_resp_valid");
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, b0.resp_valid}, 32'h1);
      chk("bp_rdata", b0.resp_rdata, 32'hDE55BEEF);
      chk("bp_error", {31'h0, b0.resp_error}, 32'h0);
      chk("bp_req_ready", {31'h0, b0.req_ready}, 32'h0);
    end
    @(posedge clk);
    #1 b0.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_req_ready", {31'h0, b0.req_ready}, 32'h1);
    chk("bp_valid_cleared", {31'h0, b0.resp_valid}, 32'h0);

    // Reset in the middle of WAIT (4 wait states)
    send(1, 1, 1, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    wait_idle(1, t0);
    send(1, 0, 1, 2'b10, 32'h20, 32'h12345678, 32'h0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wait_busy_before", {31'h0, busy1}, 32'h1);
    rst1 = 1'b1;
    #1;
    chk("rst_wait_req_ready", {31'h0, b1.req_ready}, 32'h1);
    chk("rst_wait_busy", {31'h0, busy1}, 32'h0);
    chk("rst_wait_resp_valid", {31'h0, b1.resp_valid}, 32'h0);
    chk("rst_wait_resp_error", {31'h0, b1.resp_error}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (b1.resp_valid) nv++;
    end
    chk("rst_wait_no_resp", 32'(nv), 32'h0);
    send(1, 1, 0, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 0);
    wait_idle(1, t0);

    // Back-to-back loads with no wait states: accepts 3 cycles apart, the last
    // response taken 11 edges after the first acceptance (12 cycles in all).
    send(2, 1, 1, 2'b10, 32'h0, 32'h01020304, 32'h0, 0);
    wait_idle(2, t0);
    send(2, 1, 0, 2'b10, 32'h0, 32'h0, 32'h01020304, 0);
    t0 = acc_cyc[2];
    send(2, 1, 0, 2'b00, 32'h0, 32'h0, 32'h00000001, 0);
    send(2, 1, 0, 2'b00, 32'h3, 32'h0, 32'h00000004, 0);
    send(2, 1, 0, 2'b01, 32'h2, 32'h0, 32'h00000304, 0);
    wait_idle(2, t1);
    chk("throughput", 32'(t1 - t0), 32'd11);

    wait_idle(0, t0);
    repeat (2) @(posedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q2_drained", 32'(q2.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the CPU's data-memory interface: a byte-addressed, big-endian RAM slave that accepts one load or store request at a time over a valid/ready handshake. It inserts a configurable number of wait states and returns a response with read data and an error flag. It sits between the processor's load/store path and the backing byte array, and replaces the zero-latency combinational data memory once the core moves to a handshaked memory port.

## Interface
- DEPTH_BYTES, 1024: size of the byte array; valid addresses are 0 .. DEPTH_BYTES-1.
- WAIT_CYCLES, 2: wait states between request acceptance and the response; legal range 0..15.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_addr  in  32  byte address; the lowest address holds the most-significant byte.
- req_wdata  in  32  store data, right-justified: byte in [7:0], half in [15:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data, right-justified, zero-extended; 0 for stores and for errors.
- resp_error  out  1  request was misaligned, out of range or of illegal size.
- busy  out  1  high in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. When req_valid and req_ready are both high at an edge, the responder latches write, size, addr and wdata, loads cnt with WAIT_CYCLES and goes to WAIT.
- WAIT: if cnt != 0, cnt decrements each cycle. If cnt == 0, at the next edge the access is performed, resp_valid is set, resp_rdata and resp_error are loaded, and the state goes to RESP.
- RESP: resp_valid, resp_rdata and resp_error hold stable until resp_valid and resp_ready are both high at an edge. At that edge the state returns to IDLE and resp_valid clears.
- Error check, done on the latched request:
  - size 11 is an error.
  - A halfword with addr[0] = 1 is an error.
  - A word with addr[1:0] != 0 is an error.
  - addr + nbytes > DEPTH_BYTES is an error. This check uses a 33-bit compare, so no wrap-around is possible.
- An erroring request performs no memory write, returns resp_rdata = 0 and sets resp_error = 1.
- Big-endian layout:
  - Word store: mem[a] = wdata[31:24], mem[a+1] = wdata[23:16], mem[a+2] = wdata[15:8], mem[a+3] = wdata[7:0].
  - Halfword store: mem[a] = wdata[15:8], mem[a+1] = wdata[7:0].
  - Byte store: mem[a] = wdata[7:0].
  - Loads use the same mapping in reverse; upper bits are 0.
- Input changes on the request signals while busy have no effect.
- The memory array is not cleared by reset; only control state and outputs are reset.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, busy = 0.
- req_ready and busy are decoded combinationally from state.
- Latency: if the request is accepted at edge E0, resp_valid rises after edge E0+WAIT_CYCLES+1.
- The store commits at that same edge.
- Minimum transaction period is WAIT_CYCLES+3 cycles:
  - the response is taken at edge E0+WAIT_CYCLES+2 at the earliest;
  - the next request is accepted at E0+WAIT_CYCLES+3 at the earliest.
- There is no request/response overlap and no same-cycle turnaround.
- resp_ready may be held high permanently.
- Backpressure of any length is allowed; the outputs stay frozen in RESP.
- Reset during WAIT: the pending store is discarded, memory is unchanged and no response is produced.
- Reset during RESP: the response is dropped; the store already committed remains.
- Reset wins over a handshake occurring in the same cycle.

## Test plan
- Word store then load, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to address 0x10.
  - Load the word at 0x10 -> resp_rdata = 0xDEADBEEF, resp_error = 0.
  - resp_valid rises exactly 3 cycles after acceptance.
- Sub-word loads after the store above:
  - Byte at 0x10 -> 0x000000DE.
  - Byte at 0x13 -> 0x000000EF.
  - Half at 0x12 -> 0x0000BEEF.
  - Byte store of 0x55 to 0x11, then word load at 0x10 -> 0xDE55BEEF.
- Errors, each giving resp_error = 1 and resp_rdata = 0:
  - Word at 0x12.
  - Half at 0x11.
  - size 11.
  - Word at 0x3FE.
  - Word at 0xFFFFFFFC (must not wrap).
  - A failed store to 0x3FE leaves mem[0x3FE] unchanged.
- Backpressure:
  - Hold resp_ready = 0 for 10 cycles -> resp_valid, resp_rdata and resp_error stay stable and req_ready stays 0.
  - Raise resp_ready -> IDLE one cycle later.
- Reset mid-WAIT:
  - Issue a store of 0x12345678 to 0x20 with WAIT_CYCLES = 4 and assert reset in cycle 2.
  - Outputs return to their reset values and no response appears.
  - A load of 0x20 returns the prior contents.
- Back-to-back throughput: with WAIT_CYCLES = 0 and resp_ready = 1, 4 consecutive loads complete in exactly 12 cycles.
